// File: rtl/tlul_downsizer_64to32.sv
// rtl/tlul_downsizer_64to32.sv - TL-UL 64-bit to 32-bit bus downsizer
//
// Accepts one 64-bit TL-UL request at a time and replays it on a 32-bit
// TL-UL port as one beat (size 0-2) or two beats (aligned size 3), then
// returns one merged 64-bit response.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   up_a_*          64-bit upstream request channel (up_a_ready is an output)
//   up_d_*          64-bit upstream response channel (up_d_ready is an input)
//   dn_a_*          32-bit downstream request channel (dn_a_ready is an input)
//   dn_d_*          32-bit downstream response channel (dn_d_ready is an output)
module tlul_downsizer_64to32 #(
   parameter int SourceW = 8
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               up_a_valid,
   input  logic [2:0]         up_a_opcode,
   input  logic [2:0]         up_a_param,
   input  logic [2:0]         up_a_size,
   input  logic [SourceW-1:0] up_a_source,
   input  logic [31:0]        up_a_address,
   input  logic [7:0]         up_a_mask,
   input  logic [63:0]        up_a_data,
   output logic               up_a_ready,
   output logic               up_d_valid,
   output logic [2:0]         up_d_opcode,
   output logic [2:0]         up_d_param,
   output logic [2:0]         up_d_size,
   output logic [SourceW-1:0] up_d_source,
   output logic               up_d_sink,
   output logic [63:0]        up_d_data,
   output logic               up_d_denied,
   input  logic               up_d_ready,
   output logic               dn_a_valid,
   output logic [2:0]         dn_a_opcode,
   output logic [2:0]         dn_a_param,
   output logic [1:0]         dn_a_size,
   output logic [SourceW-1:0] dn_a_source,
   output logic [31:0]        dn_a_address,
   output logic [3:0]         dn_a_mask,
   output logic [31:0]        dn_a_data,
   input  logic               dn_a_ready,
   input  logic               dn_d_valid,
   input  logic [2:0]         dn_d_opcode,
   input  logic [31:0]        dn_d_data,
   input  logic               dn_d_error,
   output logic               dn_d_ready
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

   state_e               state_q, state_d;
   logic                 init_q;
   logic [2:0]           opcode_q;
   logic [2:0]           param_q;
   logic [2:0]           size_q;
   logic [SourceW-1:0]   source_q;
   logic [31:0]          addr_q;
   logic [7:0]           mask_q;
   logic [63:0]          data_q;
   logic [63:0]          rdata_q;
   logic                 err_q;
   logic                 beat_q;

   logic                 accept;
   logic                 req_bad;
   logic                 two_beat;
   logic                 half_sel;
   logic                 in_issue;
   logic                 in_resp;
   logic                 beat_done;

   // The downstream opcode carries no information the upstream response needs.
   logic                 unused_dn_d_opcode;
   assign unused_dn_d_opcode = ^dn_d_opcode;

   assign accept = up_a_valid && up_a_ready;

   // Unsupported opcodes, misaligned 64-bit accesses, and sizes wider than the
   // 64-bit bus are answered locally with denied set.
   assign req_bad = !(up_a_opcode == 3'd0 || up_a_opcode == 3'd1 || up_a_opcode == 3'd4)
                    || (up_a_size == 3'd3 && up_a_address[2:0] != 3'b000)
                    || (up_a_size > 3'd3);

   assign two_beat  = (size_q == 3'd3);
   // Which 32-bit half of the 64-bit word the current beat targets.
   assign half_sel  = two_beat ? beat_q : addr_q[2];
   assign in_issue  = (state_q == ISSUE);
   assign in_resp   = (state_q == RESP);
   assign beat_done = (state_q == WAIT) && dn_d_valid;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      up_a_ready = 1'b0;
      dn_a_valid = 1'b0;
      dn_d_ready = 1'b0;
      up_d_valid = 1'b0;
      case (state_q)
         IDLE: begin
            up_a_ready = init_q;
            if (accept) state_d = req_bad ? RESP : ISSUE;
         end
         ISSUE: begin
            dn_a_valid = 1'b1;
            if (dn_a_ready) state_d = WAIT;
         end
         WAIT: begin
            dn_d_ready = 1'b1;
            if (dn_d_valid) state_d = (two_beat && !beat_q) ? ISSUE : RESP;
         end
         RESP: begin
            up_d_valid = 1'b1;
            if (up_d_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         init_q   <= 1'b0;
         opcode_q <= '0;
         param_q  <= '0;
         size_q   <= '0;
         source_q <= '0;
         addr_q   <= '0;
         mask_q   <= '0;
         data_q   <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         beat_q   <= 1'b0;
      end else begin
         init_q <= 1'b1;
         if (accept) begin
            opcode_q <= up_a_opcode;
            param_q  <= up_a_param;
            size_q   <= up_a_size;
            source_q <= up_a_source;
            addr_q   <= up_a_address;
            mask_q   <= up_a_mask;
            data_q   <= up_a_data;
            rdata_q  <= '0;
            // A locally rejected request starts with its error already set.
            err_q    <= req_bad;
            beat_q   <= 1'b0;
         end
         if (beat_done) begin
            err_q <= err_q | dn_d_error;
            if (two_beat) begin
               if (beat_q) rdata_q[63:32] <= dn_d_data;
               else        rdata_q[31:0]  <= dn_d_data;
               beat_q <= 1'b1;
            end else begin
               rdata_q <= {dn_d_data, dn_d_data};
            end
         end
      end
   end

   // Output fields are zero whenever their valid is low.
   assign dn_a_opcode  = in_issue ? opcode_q : 3'd0;
   assign dn_a_param   = in_issue ? param_q : 3'd0;
   assign dn_a_size    = in_issue ? (two_beat ? 2'd2 : size_q[1:0]) : 2'd0;
   assign dn_a_source  = in_issue ? source_q : '0;
   assign dn_a_address = in_issue ? (two_beat ? {addr_q[31:3], beat_q, 2'b00} : addr_q) : 32'd0;
   assign dn_a_mask    = in_issue ? (half_sel ? mask_q[7:4] : mask_q[3:0]) : 4'd0;
   assign dn_a_data    = in_issue ? (half_sel ? data_q[63:32] : data_q[31:0]) : 32'd0;

   assign up_d_opcode  = (in_resp && opcode_q == 3'd4) ? 3'd1 : 3'd0;
   assign up_d_param   = 3'd0;
   assign up_d_size    = in_resp ? size_q : 3'd0;
   assign up_d_source  = in_resp ? source_q : '0;
   assign up_d_sink    = 1'b0;
   assign up_d_data    = in_resp ? rdata_q : 64'd0;
   assign up_d_denied  = in_resp && err_q;

endmodule

// File: tb/tb_tlul_downsizer_64to32.sv
// tb/tb_tlul_downsizer_64to32.sv - directed self-checking bench for tlul_downsizer_64to32
module tb_tlul_downsizer_64to32;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        up_a_valid;
   logic [2:0]  up_a_opcode, up_a_param, up_a_size;
   logic [7:0]  up_a_source;
   logic [31:0] up_a_address;
   logic [7:0]  up_a_mask;
   logic [63:0] up_a_data;
   logic        up_a_ready;
   logic        up_d_valid;
   logic [2:0]  up_d_opcode, up_d_param, up_d_size;
   logic [7:0]  up_d_source;
   logic        up_d_sink;
   logic [63:0] up_d_data;
   logic        up_d_denied;
   logic        up_d_ready;
   logic        dn_a_valid;
   logic [2:0]  dn_a_opcode, dn_a_param;
   logic [1:0]  dn_a_size;
   logic [7:0]  dn_a_source;
   logic [31:0] dn_a_address;
   logic [3:0]  dn_a_mask;
   logic [31:0] dn_a_data;
   logic        dn_a_ready;
   logic        dn_d_valid;
   logic [2:0]  dn_d_opcode;
   logic [31:0] dn_d_data;
   logic        dn_d_error;
   logic        dn_d_ready;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   tlul_downsizer_64to32 #(.SourceW(8)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .up_a_valid(up_a_valid), .up_a_opcode(up_a_opcode), .up_a_param(up_a_param),
      .up_a_size(up_a_size), .up_a_source(up_a_source), .up_a_address(up_a_address),
      .up_a_mask(up_a_mask), .up_a_data(up_a_data), .up_a_ready(up_a_ready),
      .up_d_valid(up_d_valid), .up_d_opcode(up_d_opcode), .up_d_param(up_d_param),
      .up_d_size(up_d_size), .up_d_source(up_d_source), .up_d_sink(up_d_sink),
      .up_d_data(up_d_data), .up_d_denied(up_d_denied), .up_d_ready(up_d_ready),
      .dn_a_valid(dn_a_valid), .dn_a_opcode(dn_a_opcode), .dn_a_param(dn_a_param),
      .dn_a_size(dn_a_size), .dn_a_source(dn_a_source), .dn_a_address(dn_a_address),
      .dn_a_mask(dn_a_mask), .dn_a_data(dn_a_data), .dn_a_ready(dn_a_ready),
      .dn_d_valid(dn_d_valid), .dn_d_opcode(dn_d_opcode), .dn_d_data(dn_d_data),
      .dn_d_error(dn_d_error), .dn_d_ready(dn_d_ready)
   );

   // Presents a request on the upstream A channel; caller is at a falling edge.
   task automatic drive_req(input logic [2:0] op, input logic [2:0] sz, input logic [7:0] src,
                            input logic [31:0] addr, input logic [7:0] msk, input logic [63:0] dat);
      up_a_valid   = 1'b1;
      up_a_opcode  = op;
      up_a_param   = 3'd0;
      up_a_size    = sz;
      up_a_source  = src;
      up_a_address = addr;
      up_a_mask    = msk;
      up_a_data    = dat;
   endtask

   task automatic test_reset;
      rst_ni = 1'b0;
      up_a_valid = 0; up_a_opcode = 0; up_a_param = 0; up_a_size = 0; up_a_source = 0;
      up_a_address = 0; up_a_mask = 0; up_a_data = 0; up_d_ready = 0;
      dn_a_ready = 0; dn_d_valid = 0; dn_d_opcode = 0; dn_d_data = 0; dn_d_error = 0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({up_a_ready, up_d_valid, dn_a_valid, dn_d_ready, up_d_data, up_d_denied,
           dn_a_address, dn_a_data, dn_a_mask} !== '0)
         $display("FAIL reset_outputs: ready=%b dvalid=%b avalid=%b dready=%b ddata=%h addr=%h expected all zero",
                  up_a_ready, up_d_valid, dn_a_valid, dn_d_ready, up_d_data, dn_a_address);
      else n_pass++;
      rst_ni = 1'b1;
      #1;
      n_checks++;
      if (up_a_ready !== 1'b0) $display("FAIL reset_release_ready_early: got %b expected 0", up_a_ready);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (up_a_ready !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", up_a_ready);
      else n_pass++;
   endtask

   task automatic test_get_two_beat;
      dn_a_ready = 1; up_d_ready = 0;
      drive_req(3'd4, 3'd3, 8'h05, 32'h1000_0008, 8'hFF, 64'h0);
      @(negedge clk); up_a_valid = 0;
      n_checks++;
      if ({dn_a_valid, dn_a_address, dn_a_size, dn_a_mask, dn_a_opcode, dn_a_source, up_a_ready}
          !== {1'b1, 32'h1000_0008, 2'd2, 4'hF, 3'd4, 8'h05, 1'b0})
         $display("FAIL get64_beat0: v=%b addr=%h size=%0d mask=%h op=%0d src=%h expected 1 10000008 2 f 4 05",
                  dn_a_valid, dn_a_address, dn_a_size, dn_a_mask, dn_a_opcode, dn_a_source);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({dn_d_ready, dn_a_valid} !== 2'b10)
         $display("FAIL get64_wait0: dready=%b avalid=%b expected 1 0", dn_d_ready, dn_a_valid);
      else n_pass++;
      dn_d_valid = 1; dn_d_data = 32'h1111_1111; dn_d_error = 0;
      @(negedge clk); dn_d_valid = 0;
      n_checks++;
      if ({dn_a_valid, dn_a_address, dn_a_size} !== {1'b1, 32'h1000_000C, 2'd2})
         $display("FAIL get64_beat1: v=%b addr=%h size=%0d expected 1 1000000c 2",
                  dn_a_valid, dn_a_address, dn_a_size);
      else n_pass++;
      @(negedge clk);
      dn_d_valid = 1; dn_d_data = 32'h2222_2222;
      @(negedge clk); dn_d_valid = 0;
      n_checks++;
      if ({up_d_valid, up_d_opcode, up_d_size, up_d_source, up_d_denied, up_a_ready, up_d_param, up_d_sink}
          !== {1'b1, 3'd1, 3'd3, 8'h05, 1'b0, 1'b0, 3'd0, 1'b0})
         $display("FAIL get64_resp: v=%b op=%0d size=%0d src=%h den=%b ready=%b expected 1 1 3 05 0 0",
                  up_d_valid, up_d_opcode, up_d_size, up_d_source, up_d_denied, up_a_ready);
      else n_pass++;
      n_checks++;
      if (up_d_data !== 64'h2222_2222_1111_1111)
         $display("FAIL get64_data: got %h expected 2222222211111111", up_d_data);
      else n_pass++;
      up_d_ready = 1;
      @(negedge clk); up_d_ready = 0;
      n_checks++;
      if ({up_d_valid, up_a_ready} !== 2'b01)
         $display("FAIL get64_idle: dvalid=%b ready=%b expected 0 1", up_d_valid, up_a_ready);
      else n_pass++;
   endtask

   task automatic test_one_beat;
      // PutPartial to upper half, three-cycle latency
      dn_a_ready = 1; up_d_ready = 0;
      drive_req(3'd1, 3'd1, 8'h22, 32'h0000_0014, 8'h30, 64'hAAAA_BBBB_CCCC_DDDD);
      @(negedge clk); up_a_valid = 0;
      n_checks++;
      if ({dn_a_valid, dn_a_address, dn_a_mask, dn_a_data, dn_a_size, dn_a_opcode, dn_a_source}
          !== {1'b1, 32'h14, 4'h3, 32'hAAAA_BBBB, 2'd1, 3'd1, 8'h22})
         $display("FAIL putpartial_a: v=%b addr=%h mask=%h data=%h size=%0d op=%0d expected 1 14 3 aaaabbbb 1 1",
                  dn_a_valid, dn_a_address, dn_a_mask, dn_a_data, dn_a_size, dn_a_opcode);
      else n_pass++;
      @(negedge clk);
      dn_d_valid = 1; dn_d_data = 32'h0; dn_d_error = 0;
      @(negedge clk); dn_d_valid = 0;
      n_checks++;
      if ({up_d_valid, up_d_opcode, up_d_size, up_d_source, up_d_denied}
          !== {1'b1, 3'd0, 3'd1, 8'h22, 1'b0})
         $display("FAIL putpartial_d: v=%b op=%0d size=%0d src=%h den=%b expected 1 0 1 22 0",
                  up_d_valid, up_d_opcode, up_d_size, up_d_source, up_d_denied);
      else n_pass++;
      up_d_ready = 1;
      @(negedge clk); up_d_ready = 0;
      // Single-beat Get from lower half, data replicated
      drive_req(3'd4, 3'd2, 8'h33, 32'h0000_0020, 8'h0F, 64'h0);
      @(negedge clk); up_a_valid = 0;
      n_checks++;
      if ({dn_a_valid, dn_a_address, dn_a_mask, dn_a_size, dn_a_opcode}
          !== {1'b1, 32'h20, 4'hF, 2'd2, 3'd4})
         $display("FAIL get32_a: v=%b addr=%h mask=%h size=%0d op=%0d expected 1 20 f 2 4",
                  dn_a_valid, dn_a_address, dn_a_mask, dn_a_size, dn_a_opcode);
      else n_pass++;
      @(negedge clk);
      dn_d_valid = 1; dn_d_data = 32'hDEAD_BEEF;
      @(negedge clk); dn_d_valid = 0;
      n_checks++;
      if ({up_d_valid, up_d_opcode, up_d_size, up_d_data}
          !== {1'b1, 3'd1, 3'd2, 64'hDEAD_BEEF_DEAD_BEEF})
         $display("FAIL get32_d: v=%b op=%0d size=%0d data=%h expected 1 1 2 deadbeefdeadbeef",
                  up_d_valid, up_d_opcode, up_d_size, up_d_data);
      else n_pass++;
      up_d_ready = 1;
      @(negedge clk); up_d_ready = 0;
      // Byte PutFull to the top byte of the upper half
      drive_req(3'd0, 3'd0, 8'h44, 32'h0000_0017, 8'h80, 64'h5A00_0000_0000_00A5);
      @(negedge clk); up_a_valid = 0;
      n_checks++;
      if ({dn_a_valid, dn_a_address, dn_a_mask, dn_a_data, dn_a_size}
          !== {1'b1, 32'h17, 4'h8, 32'h5A00_0000, 2'd0})
         $display("FAIL putbyte_a: v=%b addr=%h mask=%h data=%h size=%0d expected 1 17 8 5a000000 0",
                  dn_a_valid, dn_a_address, dn_a_mask, dn_a_data, dn_a_size);
      else n_pass++;
      @(negedge clk);
      dn_d_valid = 1; dn_d_data = 32'h0;
      @(negedge clk); dn_d_valid = 0; up_d_ready = 1;
      @(negedge clk); up_d_ready = 0;
   endtask

   task automatic test_denied;
      up_d_ready = 0; dn_a_ready = 1;
      drive_req(3'd4, 3'd3, 8'h11, 32'h0000_0004, 8'hFF, 64'h0);
      @(negedge clk); up_a_valid = 0;
      n_checks++;
      if ({up_d_valid, up_d_denied, up_d_opcode, up_d_size, dn_a_valid}
          !== {1'b1, 1'b1, 3'd1, 3'd3, 1'b0})
         $display("FAIL misaligned_resp: v=%b den=%b op=%0d size=%0d avalid=%b expected 1 1 1 3 0",
                  up_d_valid, up_d_denied, up_d_opcode, up_d_size, dn_a_valid);
      else n_pass++;
      up_d_ready = 1;
      @(negedge clk); up_d_ready = 0;
      n_checks++;
      if ({up_d_valid, up_a_ready, dn_a_valid} !== 3'b010)
         $display("FAIL misaligned_idle: dvalid=%b ready=%b avalid=%b expected 0 1 0",
                  up_d_valid, up_a_ready, dn_a_valid);
      else n_pass++;
      drive_req(3'd3, 3'd2, 8'h12, 32'h0000_0008, 8'h0F, 64'h0);
      @(negedge clk); up_a_valid = 0;
      n_checks++;
      if ({up_d_valid, up_d_denied, up_d_opcode, up_d_size, up_d_source, dn_a_valid}
          !== {1'b1, 1'b1, 3'd0, 3'd2, 8'h12, 1'b0})
         $display("FAIL badop_resp: v=%b den=%b op=%0d size=%0d src=%h avalid=%b expected 1 1 0 2 12 0",
                  up_d_valid, up_d_denied, up_d_opcode, up_d_size, up_d_source, dn_a_valid);
      else n_pass++;
      up_d_ready = 1;
      @(negedge clk); up_d_ready = 0;
   endtask

   task automatic test_error_beat0;
      dn_a_ready = 1; up_d_ready = 0;
      drive_req(3'd4, 3'd3, 8'h07, 32'h0000_0100, 8'hFF, 64'h0);
      @(negedge clk); up_a_valid = 0;
      @(negedge clk);
      dn_d_valid = 1; dn_d_data = 32'hAAAA_0001; dn_d_error = 1;
      @(negedge clk); dn_d_valid = 0; dn_d_error = 0;
      n_checks++;
      if ({dn_a_valid, dn_a_address} !== {1'b1, 32'h0000_0104})
         $display("FAIL err_beat1_issued: v=%b addr=%h expected 1 00000104", dn_a_valid, dn_a_address);
      else n_pass++;
      @(negedge clk);
      dn_d_valid = 1; dn_d_data = 32'hBBBB_0002;
      @(negedge clk); dn_d_valid = 0;
      n_checks++;
      if ({up_d_valid, up_d_denied, up_d_opcode, up_d_data}
          !== {1'b1, 1'b1, 3'd1, 64'hBBBB_0002_AAAA_0001})
         $display("FAIL err_resp: v=%b den=%b op=%0d data=%h expected 1 1 1 bbbb0002aaaa0001",
                  up_d_valid, up_d_denied, up_d_opcode, up_d_data);
      else n_pass++;
      up_d_ready = 1;
      @(negedge clk); up_d_ready = 0;
   endtask

   task automatic test_backpressure;
      dn_a_ready = 0; up_d_ready = 0;
      drive_req(3'd0, 3'd2, 8'h66, 32'h0000_0044, 8'hF0, 64'h1234_5678_9ABC_DEF0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 0) up_a_valid = 0;
         n_checks++;
         if ({dn_a_valid, dn_a_address, dn_a_mask, dn_a_data, dn_a_size, dn_a_source, up_a_ready}
             !== {1'b1, 32'h44, 4'hF, 32'h1234_5678, 2'd2, 8'h66, 1'b0})
            $display("FAIL bp_a_stable[%0d]: v=%b addr=%h mask=%h data=%h size=%0d ready=%b expected 1 44 f 12345678 2 0",
                     i, dn_a_valid, dn_a_address, dn_a_mask, dn_a_data, dn_a_size, up_a_ready);
         else n_pass++;
      end
      dn_a_ready = 1;
      @(negedge clk); dn_a_ready = 0;
      dn_d_valid = 1; dn_d_data = 32'h0000_0055; dn_d_error = 0;
      @(negedge clk); dn_d_valid = 0;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if ({up_d_valid, up_d_opcode, up_d_size, up_d_source, up_d_denied, up_a_ready}
             !== {1'b1, 3'd0, 3'd2, 8'h66, 1'b0, 1'b0})
            $display("FAIL bp_d_stable[%0d]: v=%b op=%0d size=%0d src=%h den=%b ready=%b expected 1 0 2 66 0 0",
                     i, up_d_valid, up_d_opcode, up_d_size, up_d_source, up_d_denied, up_a_ready);
         else n_pass++;
         @(negedge clk);
      end
      up_d_ready = 1;
      @(negedge clk); up_d_ready = 0;
      n_checks++;
      if ({up_d_valid, up_a_ready} !== 2'b01)
         $display("FAIL bp_idle: dvalid=%b ready=%b expected 0 1", up_d_valid, up_a_ready);
      else n_pass++;
   endtask

   task automatic test_reset_mid;
      dn_a_ready = 1; up_d_ready = 0;
      drive_req(3'd4, 3'd3, 8'h09, 32'h0000_0200, 8'hFF, 64'h0);
      @(negedge clk); up_a_valid = 0;
      @(negedge clk);
      n_checks++;
      if (dn_d_ready !== 1'b1) $display("FAIL midrst_in_wait: dready=%b expected 1", dn_d_ready);
      else n_pass++;
      rst_ni = 0;
      #1;
      n_checks++;
      if ({up_a_ready, up_d_valid, dn_a_valid, dn_d_ready, up_d_data, dn_a_address, dn_a_mask, dn_a_data}
          !== '0)
         $display("FAIL midrst_outputs: ready=%b dvalid=%b avalid=%b dready=%b addr=%h expected all zero",
                  up_a_ready, up_d_valid, dn_a_valid, dn_d_ready, dn_a_address);
      else n_pass++;
      @(negedge clk);
      rst_ni = 1; dn_d_valid = 1; dn_d_data = 32'hCAFE_F00D;
      #1;
      n_checks++;
      if (up_a_ready !== 1'b0) $display("FAIL midrst_ready_early: got %b expected 0", up_a_ready);
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if ({up_a_ready, dn_a_valid, dn_d_ready, up_d_valid} !== 4'b1000)
            $display("FAIL midrst_after[%0d]: ready=%b avalid=%b dready=%b dvalid=%b expected 1 0 0 0",
                     i, up_a_ready, dn_a_valid, dn_d_ready, up_d_valid);
         else n_pass++;
      end
      dn_d_valid = 0;
   endtask

   initial begin
      test_reset();
      test_get_two_beat();
      test_one_beat();
      test_denied();
      test_error_beat0();
      test_backpressure();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/tlul_downsizer_64to32.md
TLUL_DOWNSIZER_64TO32 -- requirements
Module: tlul_downsizer_64to32

Interface
REQ-001 SHALL have parameter SourceW, default 8, meaning the width of the a/d source ID on both sides.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state is clocked on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have upstream A-channel inputs:
- up_a_valid, 1 bit
- up_a_opcode, 3 bits
- up_a_param, 3 bits
- up_a_size, 3 bits
- up_a_source, SourceW bits
- up_a_address, 32 bits
- up_a_mask, 8 bits
- up_a_data, 64 bits
REQ-005 SHALL have upstream A-channel output up_a_ready, 1 bit.
REQ-006 SHALL have upstream D-channel outputs:
- up_d_valid, 1 bit
- up_d_opcode, 3 bits
- up_d_param, 3 bits
- up_d_size, 3 bits
- up_d_source, SourceW bits
- up_d_sink, 1 bit
- up_d_data, 64 bits
- up_d_denied, 1 bit
REQ-007 SHALL have upstream D-channel input up_d_ready, 1 bit.
REQ-008 SHALL have downstream 32-bit TL-UL A-channel outputs:
- dn_a_valid, 1 bit
- dn_a_opcode, 3 bits
- dn_a_param, 3 bits
- dn_a_size, 2 bits
- dn_a_source, SourceW bits
- dn_a_address, 32 bits
- dn_a_mask, 4 bits
- dn_a_data, 32 bits
REQ-009 SHALL have downstream A-channel input dn_a_ready, 1 bit.
REQ-010 SHALL have downstream D-channel inputs:
- dn_d_valid, 1 bit
- dn_d_opcode, 3 bits
- dn_d_data, 32 bits
- dn_d_error, 1 bit
REQ-011 SHALL have downstream D-channel output dn_d_ready, 1 bit.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP, with at most one upstream transaction outstanding.
REQ-013 SHALL drive up_a_ready=1 only in IDLE; an upstream request is accepted when up_a_valid and up_a_ready are both 1.
REQ-014 On acceptance SHALL capture opcode, param, size, source, address, mask and data, and clear the sticky error and the beat index.
REQ-015 SHALL treat opcodes 0 (PutFull), 1 (PutPartial) and 4 (Get) as supported; any other opcode goes IDLE->RESP with denied=1 and no downstream access.
REQ-016 SHALL treat size 3 with address[2:0]!=0 as misaligned and go IDLE->RESP with denied=1 and no downstream access.
REQ-017 Size 3 (aligned) SHALL split into two beats:
- beat 0: address[31:3] followed by 3'b000, mask[3:0], data[31:0]
- beat 1: address+4, mask[7:4], data[63:32]
- dn_a_size=2 on both beats
REQ-018 Size 0-2 SHALL be one beat:
- dn_a_address = captured address
- dn_a_size = captured size[1:0]
- address[2]=0: mask[3:0] and data[31:0]
- address[2]=1: mask[7:4] and data[63:32]
REQ-019 In ISSUE SHALL hold dn_a_valid=1 with stable fields (dn_a_opcode=opcode, param, source) until dn_a_ready; on handshake go to WAIT.
REQ-020 In WAIT SHALL drive dn_d_ready=1; on dn_d_valid:
- store dn_d_data in data half [beat]
- OR dn_d_error into the sticky error
- go to ISSUE for beat 1 if pending, else RESP
REQ-021 A beat-0 error SHALL NOT suppress beat 1.
REQ-022 For one-beat reads, up_d_data SHALL be {d,d}, i.e. the 32-bit response replicated in both halves.
REQ-023 In RESP SHALL drive up_d_valid=1 with:
- up_d_opcode=1 (AccessAckData) for Get, else 0 (AccessAck)
- up_d_size = captured size
- up_d_source = captured source
- up_d_param=0, up_d_sink=0
- up_d_denied = sticky error
REQ-024 RESP SHALL hold until up_d_ready=1, then go to IDLE; a new request cannot be accepted in the same cycle.
REQ-025 dn_d_ready SHALL be 0 outside WAIT; downstream responses outside WAIT are not consumed.
REQ-026 Minimum latency from up_a handshake to up_d_valid SHALL be 3 cycles for one beat (dn_a_ready and dn_d_valid held at 1) and 5 cycles for two beats.
REQ-027 dn_a_* and up_d_* outputs SHALL be registered or derived only from state registers, with no combinational path from upstream inputs.

Reset
REQ-028 While rst_ni=0 SHALL force state=IDLE and zero all captured registers.
REQ-029 While rst_ni=0 SHALL hold outputs at 0: up_a_ready, up_d_valid, dn_a_valid, dn_d_ready and all data/control fields.
REQ-030 up_a_ready SHALL rise on the first rising clock edge after rst_ni deasserts, via a registered init flag.
REQ-031 Reset asserted mid-transaction SHALL abort it immediately, drop captured data, and issue no further downstream beats after release.

Verification
REQ-032 Get size=3 addr=0x1000_0008, downstream returns 0x1111_1111 then 0x2222_2222 -> dn addresses 0x1000_0008 then 0x1000_000C; up_d_data=0x2222_2222_1111_1111, opcode=1, denied=0.
REQ-033 PutPartial size=1 addr=0x14 mask=0x30 data[63:32]=0xAAAA_BBBB -> one beat with dn_a_mask=0x3, dn_a_data=0xAAAA_BBBB, dn_a_size=1; up_d_opcode=0.
REQ-034 Get size=3 addr=0x4 -> no dn_a_valid; up_d_denied=1 within 2 cycles. Opcode 3 -> same response.
REQ-035 Size-3 Get with dn_d_error=1 on beat 0 only -> beat 1 still issued; up_d_denied=1.
REQ-036 Backpressure: dn_a_ready=0 for 5 cycles, then up_d_ready=0 for 4 cycles -> dn_a fields and up_d fields stable throughout; up_a_ready=0 throughout.
REQ-037 Assert rst_ni low during WAIT of beat 0 -> all outputs 0; after release there is no beat 1 and up_a_ready=1 one cycle later.
